// File: rtl/fifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Purpose  : Read-side consumer for the async FIFO. Drains the show-ahead
//             read port one DSIZE entry per pop, packs NBYTES entries into
//             one OW-bit word (lane 0 = oldest) and presents it on a
//             valid/ready stream. A flush request forces out a partial word
//             with a lane-keep mask.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_fifo_rdata / i_fifo_empty / o_fifo_rd : FIFO read port
//             i_flush / o_flush_busy                  : partial-word flush
//             o_tdata / o_tkeep / o_tvalid / i_tready : output stream
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DSIZE  = 8,
    parameter int NBYTES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DSIZE-1:0]        i_fifo_rdata,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_rd,
    input  logic                    i_flush,
    output logic [DSIZE*NBYTES-1:0] o_tdata,
    output logic [NBYTES-1:0]       o_tkeep,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_flush_busy
);

    localparam int              OW     = DSIZE * NBYTES;
    localparam int              c_CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NBYTES - 1);

    logic [OW-1:0]     r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [OW-1:0]     r_tdata;
    logic [NBYTES-1:0] r_tkeep;
    logic              r_tvalid;
    logic              r_flush_pend;

    logic              w_out_free;
    logic              w_last;
    logic              w_pop;
    logic              w_flush_go;
    logic [OW-1:0]     w_acc_wr;     // accumulator with the popped entry in lane r_cnt
    logic [OW-1:0]     w_part_data;  // accumulator with lanes >= r_cnt zeroed
    logic [NBYTES-1:0] w_lane_used;  // (1 << r_cnt) - 1

    assign w_out_free = !r_tvalid || i_tready;
    assign w_last     = (r_cnt == c_LAST);
    // Reset gates the pop so the FIFO is never drained while we hold reset.
    assign w_pop      = i_rst_n && !i_fifo_empty && !r_flush_pend
                        && (!w_last || w_out_free);
    // Pops are blocked while a flush is pending, so a pop and a flush
    // execution never share an edge.
    assign w_flush_go = r_flush_pend && w_out_free;

    generate
        for (genvar g = 0; g < NBYTES; g++) begin : g_lane
            assign w_lane_used[g] = (c_CW'(g) < r_cnt);
            assign w_acc_wr[g*DSIZE +: DSIZE] =
                (r_cnt == c_CW'(g)) ? i_fifo_rdata : r_acc[g*DSIZE +: DSIZE];
            assign w_part_data[g*DSIZE +: DSIZE] =
                w_lane_used[g] ? r_acc[g*DSIZE +: DSIZE] : {DSIZE{1'b0}};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tvalid     <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            // The pop decision was made before this flag is seen, so a pop
            // may still complete on the edge that captures the request.
            if (i_flush && !r_flush_pend) begin
                r_flush_pend <= 1'b1;
            end

            // Handshake drop; overridden below if the register reloads.
            if (r_tvalid && i_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_pop) begin
                r_acc <= w_acc_wr;
                if (w_last) begin
                    // On the last lane w_acc_wr is {new entry, lanes 0..N-2}.
                    r_tdata  <= w_acc_wr;
                    r_tkeep  <= '1;
                    r_tvalid <= 1'b1;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_flush_go) begin
                r_flush_pend <= 1'b0;
                if (r_cnt != '0) begin
                    r_tdata  <= w_part_data;
                    r_tkeep  <= w_lane_used;
                    r_tvalid <= 1'b1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
            end
        end
    end

    assign o_fifo_rd    = w_pop;
    assign o_tdata      = r_tdata;
    assign o_tkeep      = r_tkeep;
    assign o_tvalid     = r_tvalid;
    assign o_flush_busy = r_flush_pend;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Purpose  : Self-checking bench for fifo_rd_packer (DSIZE=8, NBYTES=4).
//             A queue models the FIFO contents; every popped entry goes to a
//             scoreboard and every accepted output word is checked lane by
//             lane against it, plus directed checks of timing and values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rdata;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        flush;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        flush_busy;

    always #5 clk = ~clk;

    fifo_rd_packer #(.DSIZE(8), .NBYTES(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fifo_rdata (rdata),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (fifo_rd),
        .i_flush      (flush),
        .o_tdata      (tdata),
        .o_tkeep      (tkeep),
        .o_tvalid     (tvalid),
        .i_tready     (tready),
        .o_flush_busy (flush_busy)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  sb[$];
    bit          gap, tready_v, flush_v;
    logic        pre_rd, pre_acc, pre_empty;
    logic [31:0] pre_tdata;
    logic [3:0]  pre_tkeep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_empty = gap || (fifo_q.size() == 0);
        rdata      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        tready     = tready_v;
        flush      = flush_v;
    endtask

    // Compare an accepted word against the scoreboard.
    task automatic check_word(input logic [31:0] d, input logic [3:0] k);
        chk("tkeep_contig", {31'd0, ((k & (k + 1)) == 0) && (k != 0)}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                chk("sb_underflow", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) chk("lane_data", {24'd0, d[i*8 +: 8]}, {24'd0, sb.pop_front()});
            end else begin
                chk("unused_lane_zero", {24'd0, d[i*8 +: 8]}, 32'd0);
            end
        end
    endtask

    // One clock: drive at negedge, sample just before and just after posedge.
    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        pre_rd    = fifo_rd;
        pre_empty = fifo_empty;
        pre_acc   = tvalid && tready;
        pre_tdata = tdata;
        pre_tkeep = tkeep;
        @(posedge clk);
        #1;
        if (pre_acc) check_word(pre_tdata, pre_tkeep);
        if (pre_rd) begin
            chk("rd_while_empty", {31'd0, pre_empty}, 32'd0);
            if (!pre_empty) sb.push_back(fifo_q.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pushed;
        // ---------------- reset ----------------
        rst_n = 1'b0; gap = 0; tready_v = 1; flush_v = 0;
        fifo_q = '{8'h01, 8'h02, 8'h03};
        drive();
        @(posedge clk); #1;
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_tvalid",  {31'd0, tvalid}, 32'd0);
        chk("rst_tdata",   tdata, 32'd0);
        chk("rst_tkeep",   {28'd0, tkeep}, 32'd0);
        fifo_q.delete();
        sb.delete();
        drive();
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- streaming ----------------
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tready_v = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("stream_tvalid", {31'd0, tvalid}, {31'd0, (k == 4) || (k == 8)});
            if (k == 4) begin
                chk("stream_w0", tdata, 32'h44332211);
                chk("stream_k0", {28'd0, tkeep}, 32'hF);
            end
            if (k == 8) begin
                chk("stream_w1", tdata, 32'h88776655);
                chk("stream_k1", {28'd0, tkeep}, 32'hF);
            end
        end
        tick();
        chk("stream_drained", {31'd0, tvalid}, 32'd0);

        // ---------------- backpressure ----------------
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tready_v = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("bp_pop", {31'd0, pre_rd}, 32'd1);
        end
        tick();
        chk("bp_stall_rd", {31'd0, pre_rd}, 32'd0);
        chk("bp_held_data", tdata, 32'h44332211);
        chk("bp_held_valid", {31'd0, tvalid}, 32'd1);
        chk("bp_fifo_left", fifo_q.size(), 32'd1);
        tready_v = 1;
        tick();
        chk("bp_release_rd", {31'd0, pre_rd}, 32'd1);
        chk("bp_release_acc", {31'd0, pre_acc}, 32'd1);
        chk("bp_reload_data", tdata, 32'h88776655);
        chk("bp_reload_valid", {31'd0, tvalid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, tvalid}, 32'd0);

        // ---------------- partial flush ----------------
        fifo_q = '{8'hAA, 8'hBB};
        tick(); tick();
        flush_v = 1;
        tick();
        chk("pf_busy_set", {31'd0, flush_busy}, 32'd1);
        chk("pf_not_yet", {31'd0, tvalid}, 32'd0);
        flush_v = 0;
        tick();
        chk("pf_valid", {31'd0, tvalid}, 32'd1);
        chk("pf_data", tdata, 32'h0000BBAA);
        chk("pf_keep", {28'd0, tkeep}, 32'h3);
        chk("pf_busy_clr", {31'd0, flush_busy}, 32'd0);
        tick();
        chk("pf_drained", {31'd0, tvalid}, 32'd0);
        flush_v = 1;
        tick();
        chk("pf0_busy", {31'd0, flush_busy}, 32'd1);
        flush_v = 0;
        tick();
        chk("pf0_no_valid", {31'd0, tvalid}, 32'd0);
        chk("pf0_busy_clr", {31'd0, flush_busy}, 32'd0);
        tick();
        chk("pf0_no_valid2", {31'd0, tvalid}, 32'd0);

        // ---------------- flush against blocked output ----------------
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        tready_v = 0;
        for (int k = 1; k <= 4; k++) tick();
        flush_v = 1;
        tick();
        chk("fb_same_edge_pop", {31'd0, pre_rd}, 32'd1);
        chk("fb_busy", {31'd0, flush_busy}, 32'd1);
        flush_v = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fb_no_rd", {31'd0, pre_rd}, 32'd0);
            chk("fb_held", tdata, 32'h04030201);
            chk("fb_busy_hold", {31'd0, flush_busy}, 32'd1);
        end
        tready_v = 1;
        tick();
        chk("fb_no_rd_at_exec", {31'd0, pre_rd}, 32'd0);
        chk("fb_part_valid", {31'd0, tvalid}, 32'd1);
        chk("fb_part_data", tdata, 32'h00000005);
        chk("fb_part_keep", {28'd0, tkeep}, 32'h1);
        chk("fb_busy_clr", {31'd0, flush_busy}, 32'd0);
        tick();
        chk("fb_resume_rd", {31'd0, pre_rd}, 32'd1);
        tick();
        flush_v = 1;
        tick();
        flush_v = 0;
        tick();
        chk("fb_fresh_data", tdata, 32'h00000706);
        chk("fb_fresh_keep", {28'd0, tkeep}, 32'h3);
        tick();

        // ---------------- random soak ----------------
        pushed = 0;
        cyc    = 0;
        while ((pushed < 2000 || fifo_q.size() != 0) && cyc < 20000) begin
            if (pushed < 2000 && $urandom_range(0, 2) != 0) begin
                fifo_q.push_back(8'($urandom));
                pushed++;
            end
            gap      = ($urandom_range(0, 3) == 0);
            tready_v = ($urandom_range(0, 2) != 0);
            flush_v  = ($urandom_range(0, 31) == 0);
            tick();
            cyc++;
        end
        chk("soak_timeout", {31'd0, cyc < 20000}, 32'd1);
        gap = 0; tready_v = 1; flush_v = 1;
        tick(); tick();
        flush_v = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("soak_fifo_empty", fifo_q.size(), 32'd0);
        chk("soak_sb_empty", sb.size(), 32'd0);
        chk("soak_final_idle", {31'd0, tvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
